stack_unit: RTL and testbench
=============================

# stack_unit

- Hardware LIFO behind the processor's push-in (aluOp 0110) and pop-out (aluOp 0111) instructions.
- The ALU forwards the operand on push; the stack returns the top-of-stack value on pop, which the datapath writes into the accumulator.
- Provides full/empty status, an occupancy count, a random-access peek port for debug, and sticky overflow/underflow error flags for the flag/acknowledge path.

## Interface

Parameters:
- DEPTH, default 8: number of 8-bit entries. Power of two, ≥ 2.
- CW, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  push din this cycle.
- pop  input  1  pop the top entry this cycle.
- din  input  8  data to push (ALU result).
- clr_err  input  1  clears ovf and unf.
- peek_idx  input  $clog2(DEPTH)  depth below top to read; 0 = top.
- dout  output  8  current top of stack; 0 when empty.
- peek_data  output  8  entry at depth peek_idx; 0 if peek_idx ≥ count.
- count  output  CW  occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky: a push was rejected.
- unf  output  1  sticky: a pop was rejected.

## Operation

- Storage: DEPTH × 8 register array plus stack pointer sp (= count). Entry sp-1 is the top. The array is not reset.
- dout, peek_data, empty and full are combinational from the array and sp. The consumer samples dout in the same cycle it asserts pop.
- Command resolution per cycle:
  - idle (push=0, pop=0): no change.
  - push only, not full: mem[sp] ← din, sp ← sp+1.
  - push only, full: no write, sp unchanged, ovf ← 1.
  - pop only, not empty: sp ← sp-1. The entry is left in place but becomes invisible.
  - pop only, empty: sp unchanged, unf ← 1.
  - push and pop, not empty (full included): replace top, mem[sp-1] ← din, sp unchanged. No flags set.
  - push and pop, empty: push proceeds (mem[0] ← din, sp ← 1) and unf ← 1.
- Error flags:
  - clr_err clears both ovf and unf.
  - If clr_err coincides with a new error event in the same cycle, the set wins and the flag reads 1 afterward.
- Peek: peek_data = mem[sp-1-peek_idx] when peek_idx < sp, else 0. No side effects.
- Widths: sp arithmetic is CW bits. Writes index mem with the low $clog2(DEPTH) bits, so sp never wraps; rejected ops guarantee 0 ≤ sp ≤ DEPTH.

## Timing

- Reset (reset=1 at an edge):
  - sp=0, ovf=0, unf=0.
  - Hence dout=0, peek_data=0, count=0, empty=1, full=0.
  - reset overrides push, pop and clr_err in the same cycle.
  - Reset during any sequence of operations discards all entries.
- Latency:
  - Push: data is visible on dout the cycle after the push edge.
  - Pop: the popped value is on dout during the pop cycle; the next entry appears the following cycle.
  - Replace: the new top is visible the next cycle.
- Flags:
  - count, empty and full update one cycle after the command.
  - ovf and unf assert the cycle after the offending command.
- No handshake stalls: every command completes in one cycle. Back-to-back operations are sustained every cycle.

## Test plan

1. Reset then idle: count=0, empty=1, full=0, dout=0, ovf=unf=0.
2. Push 0x11, 0x22, 0x33 on consecutive cycles: dout=0x33, count=3, peek_idx=2 gives 0x11, peek_idx=3 gives 0. Then pop three times: dout reads 0x33, 0x22, 0x11 in the pop cycles, and empty=1 afterward.
3. Fill with 8 pushes of 0xA0..0xA7: full=1, count=8. A ninth push of 0xFF gives ovf=1, dout still 0xA7, count still 8. Then push+pop with 0x5A gives dout=0x5A, count=8, and ovf stays 1.
4. Pop when empty: unf=1, count=0. Then push+pop with 0x77 while empty gives count=1, dout=0x77, unf=1. Then clr_err gives ovf=unf=0.
5. Push and clr_err together while full: ovf=1 after the edge (set beats clear).
6. With count=5, assert reset together with push 0x99: count=0, empty=1, dout=0, flags 0. A subsequent push 0x42 gives dout=0x42, count=1.

Source files
------------

// File: rtl/stack_unit.sv
// Hardware LIFO for the push-in / pop-out instructions: DEPTH x 8-bit register
// stack with combinational top/peek reads, occupancy status and sticky error flags.
module stack_unit #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  input  logic                     clr_err,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [7:0]               dout,
  output logic [7:0]               peek_data,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] sp;
  logic [CW-1:0] sp_next;
  logic [AW-1:0] top_idx;
  logic [CW-1:0] peek_pos;
  logic          do_write;
  logic [AW-1:0] wr_idx;
  logic          set_ovf;
  logic          set_unf;

  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == CW'(DEPTH));
  assign top_idx  = AW'(sp - CW'(1));
  assign peek_pos = sp - CW'(1) - CW'(peek_idx);

  assign dout      = empty ? 8'h00 : mem[top_idx];
  assign peek_data = (CW'(peek_idx) < sp) ? mem[AW'(peek_pos)] : 8'h00;

  // Resolve the push/pop pair into a single write, pointer update and error events.
  always_comb begin
    sp_next  = sp;
    do_write = 1'b0;
    wr_idx   = AW'(sp);
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          do_write = 1'b1;
          wr_idx   = AW'(sp);
          sp_next  = sp + CW'(1);
        end
      end
      2'b01: begin
        if (empty) set_unf = 1'b1;
        else       sp_next = sp - CW'(1);
      end
      2'b11: begin
        // Simultaneous push/pop replaces the top; on an empty stack the push still lands.
        if (empty) begin
          do_write = 1'b1;
          wr_idx   = '0;
          sp_next  = CW'(1);
          set_unf  = 1'b1;
        end else begin
          do_write = 1'b1;
          wr_idx   = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && do_write) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp <= sp_next;
      // A new error event wins over a coincident clear.
      if (set_ovf)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (set_unf)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (DEPTH=8): push/pop ordering,
// overflow/underflow, replace, error clear priority and reset override.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic       clr_err;
  logic [2:0] peek_idx;
  logic [7:0] dout;
  logic [7:0] peek_data;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int errors = 0;

  stack_unit #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .peek_idx(peek_idx), .dout(dout), .peek_data(peek_data),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00; clr_err = 1'b0; peek_idx = 3'd0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b exp 0", full); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got %h exp 00", dout); end
    checks++; if (peek_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_peek got %h exp 00", peek_data); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b exp 00", {ovf, unf}); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'h33; exp_pop[1] = 8'h22; exp_pop[2] = 8'h11;
    push = 1'b1; din = 8'h11; cycle();
    din = 8'h22; cycle();
    din = 8'h33; cycle();
    push = 1'b0;
    checks++; if (dout !== 8'h33) begin errors++; $display("[TB] FAIL pp_dout got %h exp 33", dout); end
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL pp_count got %0d exp 3", count); end
    peek_idx = 3'd2; #1;
    checks++; if (peek_data !== 8'h11) begin errors++; $display("[TB] FAIL pp_peek2 got %h exp 11", peek_data); end
    peek_idx = 3'd1; #1;
    checks++; if (peek_data !== 8'h22) begin errors++; $display("[TB] FAIL pp_peek1 got %h exp 22", peek_data); end
    peek_idx = 3'd3; #1;
    checks++; if (peek_data !== 8'h00) begin errors++; $display("[TB] FAIL pp_peek3 got %h exp 00", peek_data); end
    peek_idx = 3'd0;
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dout !== exp_pop[i]) begin
        errors++; $display("[TB] FAIL pp_pop%0d got %h exp %h", i, dout, exp_pop[i]);
      end
      cycle();
    end
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL pp_empty got %b exp 1", empty); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL pp_dout_empty got %h exp 00", dout); end
  endtask

  task automatic test_overflow();
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'hA0 + 8'(i);
      cycle();
    end
    push = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL ov_full got %b exp 1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL ov_count got %0d exp 8", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ov_pre got %b exp 0", ovf); end
    push = 1'b1; din = 8'hFF; cycle(); push = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ov_flag got %b exp 1", ovf); end
    checks++; if (dout !== 8'hA7) begin errors++; $display("[TB] FAIL ov_dout got %h exp a7", dout); end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL ov_count2 got %0d exp 8", count); end
    peek_idx = 3'd7; #1;
    checks++; if (peek_data !== 8'hA0) begin errors++; $display("[TB] FAIL ov_peek7 got %h exp a0", peek_data); end
    peek_idx = 3'd0;
    push = 1'b1; pop = 1'b1; din = 8'h5A; cycle(); push = 1'b0; pop = 1'b0;
    checks++; if (dout !== 8'h5A) begin errors++; $display("[TB] FAIL rep_dout got %h exp 5a", dout); end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL rep_count got %0d exp 8", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL rep_ovf got %b exp 1", ovf); end
    peek_idx = 3'd1; #1;
    checks++; if (peek_data !== 8'hA6) begin errors++; $display("[TB] FAIL rep_peek1 got %h exp a6", peek_data); end
    peek_idx = 3'd0;
  endtask

  task automatic test_underflow();
    logic [7:0] expv;
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expv = (i == 0) ? 8'h5A : 8'hA7 - 8'(i);
      #1;
      checks++;
      if (dout !== expv) begin
        errors++; $display("[TB] FAIL drain%0d got %h exp %h", i, dout, expv);
      end
      cycle();
    end
    checks++; if (unf !== 1'b0) begin errors++; $display("[TB] FAIL un_pre got %b exp 0", unf); end
    cycle();
    pop = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("[TB] FAIL un_flag got %b exp 1", unf); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL un_count got %0d exp 0", count); end
    push = 1'b1; pop = 1'b1; din = 8'h77; cycle(); push = 1'b0; pop = 1'b0;
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL pe_count got %0d exp 1", count); end
    checks++; if (dout !== 8'h77) begin errors++; $display("[TB] FAIL pe_dout got %h exp 77", dout); end
    checks++; if (unf !== 1'b1) begin errors++; $display("[TB] FAIL pe_unf got %b exp 1", unf); end
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("[TB] FAIL clr_flags got %b exp 00", {ovf, unf}); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL clr_count got %0d exp 1", count); end
  endtask

  task automatic test_set_beats_clear();
    push = 1'b1;
    for (int i = 1; i < 8; i++) begin
      din = 8'hB0 + 8'(i);
      cycle();
    end
    din = 8'hEE; clr_err = 1'b1; cycle();
    push = 1'b0; clr_err = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL sbc_ovf got %b exp 1", ovf); end
    checks++; if (dout !== 8'hB7) begin errors++; $display("[TB] FAIL sbc_dout got %h exp b7", dout); end
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL sbc_clear got %b exp 0", ovf); end
  endtask

  task automatic test_reset_override();
    reset = 1'b1; cycle(); reset = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'hC0 + 8'(i);
      cycle();
    end
    push = 1'b0; pop = 1'b1; cycle(); cycle(); pop = 1'b0;
    checks++; if (unf !== 1'b0) begin errors++; $display("[TB] FAIL ro_noerr got %b exp 0", unf); end
    push = 1'b1; din = 8'hD0; cycle(); din = 8'hD1; cycle(); push = 1'b0;
    checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL ro_count5 got %0d exp 5", count); end
    checks++; if (dout !== 8'hD1) begin errors++; $display("[TB] FAIL ro_dout5 got %h exp d1", dout); end
    reset = 1'b1; push = 1'b1; din = 8'h99; clr_err = 1'b0; cycle();
    reset = 1'b0; push = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL ro_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL ro_empty got %b exp 1", empty); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL ro_dout got %h exp 00", dout); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("[TB] FAIL ro_flags got %b exp 00", {ovf, unf}); end
    push = 1'b1; din = 8'h42; cycle(); push = 1'b0;
    checks++; if (dout !== 8'h42) begin errors++; $display("[TB] FAIL ro_push_dout got %h exp 42", dout); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL ro_push_count got %0d exp 1", count); end
    peek_idx = 3'd1; #1;
    checks++; if (peek_data !== 8'h00) begin errors++; $display("[TB] FAIL ro_peek1 got %h exp 00", peek_data); end
    peek_idx = 3'd0;
  endtask

  task automatic test_back_to_back();
    push = 1'b1; din = 8'hE1; cycle();
    din = 8'hE2; cycle();
    pop = 1'b1; din = 8'hE3; cycle();
    push = 1'b0; #1;
    checks++; if (dout !== 8'hE3) begin errors++; $display("[TB] FAIL b2b_rep got %h exp e3", dout); end
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 3", count); end
    cycle();
    checks++; if (dout !== 8'hE1) begin errors++; $display("[TB] FAIL b2b_pop got %h exp e1", dout); end
    pop = 1'b0; push = 1'b1; din = 8'hE4; cycle(); push = 1'b0;
    checks++; if (dout !== 8'hE4) begin errors++; $display("[TB] FAIL b2b_push got %h exp e4", dout); end
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL b2b_count2 got %0d exp 3", count); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_set_beats_clear();
    test_reset_override();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
